// File: rtl/mips_mc_control.sv
// Main control FSM for the multi-cycle MIPS core: Moore outputs drive every datapath select/enable.
// Optional `MC_CTRL_BNE_EN routes opcode 000101 (bne) through the BEQ state with BranchNe set.
module mips_mc_control #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [OP_WIDTH-1:0]    Op,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   BranchNe,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUOp,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   Illegal,
  output logic [STATE_WIDTH-1:0] State
);

  localparam logic [STATE_WIDTH-1:0] FETCH  = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] DECODE = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] MEMADR = STATE_WIDTH'(2);
  localparam logic [STATE_WIDTH-1:0] MEMRD  = STATE_WIDTH'(3);
  localparam logic [STATE_WIDTH-1:0] MEMWB  = STATE_WIDTH'(4);
  localparam logic [STATE_WIDTH-1:0] MEMWR  = STATE_WIDTH'(5);
  localparam logic [STATE_WIDTH-1:0] RTEX   = STATE_WIDTH'(6);
  localparam logic [STATE_WIDTH-1:0] RTWB   = STATE_WIDTH'(7);
  localparam logic [STATE_WIDTH-1:0] BEQ    = STATE_WIDTH'(8);
  localparam logic [STATE_WIDTH-1:0] JMP    = STATE_WIDTH'(9);
  localparam logic [STATE_WIDTH-1:0] ADDIEX = STATE_WIDTH'(10);
  localparam logic [STATE_WIDTH-1:0] ADDIWB = STATE_WIDTH'(11);

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
`ifdef MC_CTRL_BNE_EN
  localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(6'b000101);
`endif

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
  } ctrl_t;

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic                   illegal_dec;
  ctrl_t                  ctrl;

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state: Op only matters in DECODE and MEMADR, where the IR is stable.
  always_comb begin
    state_d     = FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTEX;
          OP_BEQ:       state_d = BEQ;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = BEQ;
`endif
          OP_J:         state_d = JMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d     = FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      RTEX:   state_d = RTWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore output table; reset overrides everything so no write enable fires mid-abort.
  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.pcwrite = 1'b1;
      end
      DECODE: ctrl.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      RTEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b10;
      end
      RTWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ADDIWB: ctrl.regwrite = 1'b1;
      BEQ: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = 2'b01;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = 2'b01;
      end
      JMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = 2'b10;
      end
      default: ctrl = '0;
    endcase
    if (!Reset) ctrl = '0;
  end

  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign IRWrite     = ctrl.irwrite;
  assign PCSource    = ctrl.pcsource;
  assign ALUOp       = ctrl.aluop;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign Illegal     = Reset & (state_q == DECODE) & illegal_dec;
  assign State       = Reset ? state_q : FETCH;

`ifdef MC_CTRL_BNE_EN
  // Remember which branch flavour was decoded so BranchNe stays a pure state output.
  logic bne_q;
  always_ff @(posedge CLK) begin
    if (!Reset)                 bne_q <= 1'b0;
    else if (state_q == DECODE) bne_q <= (Op == OP_BNE);
  end
  assign BranchNe = Reset & (state_q == BEQ) & bne_q;
`else
  assign BranchNe = 1'b0;
`endif

  mem_excl_a: assert property (@(posedge CLK) !(MemRead && MemWrite));
  pc_excl_a:  assert property (@(posedge CLK) !(PCWrite && PCWriteCond));

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench: driver pushes the expected output vector per cycle, monitor pops at negedge.
module tb_mips_mc_control;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, Illegal;
  logic [3:0] State;

  always #5 CLK = ~CLK;

  mips_mc_control #(.OP_WIDTH(6), .STATE_WIDTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegDst(RegDst), .Illegal(Illegal), .State(State)
  );

  typedef struct packed {
    logic       pcwrite, pcwritecond, branchne, iord, memread, memwrite, memtoreg, irwrite;
    logic [1:0] pcsource, aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite, regdst, illegal;
    logic [3:0] state;
  } vec_t;

  vec_t  act;
  vec_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  always_comb begin
    act = '{PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal, State};
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BQ = 6'b000100,
                         JP = 6'b000010, AI = 6'b001000, BN = 6'b000101, BAD = 6'b111111;

  function automatic bit legal(input logic [5:0] op);
    legal = (op == LW) || (op == SW) || (op == RT) || (op == BQ) || (op == JP) || (op == AI);
`ifdef MC_CTRL_BNE_EN
    if (op == BN) legal = 1'b1;
`endif
  endfunction

  // Hand-written output table for each state code.
  function automatic vec_t exp_vec(input logic [3:0] st, input bit ill, input bit bne);
    vec_t v;
    v = '0;
    v.state = st;
    case (st)
      4'd0:        begin v.memread = 1; v.irwrite = 1; v.alusrcb = 2'b01; v.pcwrite = 1; end
      4'd1:        begin v.alusrcb = 2'b11; v.illegal = ill; end
      4'd2, 4'd10: begin v.alusrca = 1; v.alusrcb = 2'b10; end
      4'd3:        begin v.memread = 1; v.iord = 1; end
      4'd4:        begin v.regwrite = 1; v.memtoreg = 1; end
      4'd5:        begin v.memwrite = 1; v.iord = 1; end
      4'd6:        begin v.alusrca = 1; v.aluop = 2'b10; end
      4'd7:        begin v.regwrite = 1; v.regdst = 1; end
      4'd8:        begin v.alusrca = 1; v.aluop = 2'b01; v.pcwritecond = 1; v.pcsource = 2'b01;
                         v.branchne = bne; end
      4'd9:        begin v.pcwrite = 1; v.pcsource = 2'b10; end
      4'd11:       v.regwrite = 1;
      default:     v = '0;
    endcase
    return v;
  endfunction

  task automatic step(input bit rst, input logic [5:0] op, input logic [3:0] st, input string nm);
    vec_t v;
    @(posedge CLK);
    #1;
    Reset = rst;
    Op    = op;
    if (!rst) v = '0;
    else v = exp_vec(st, (st == 4'd1) && !legal(op), (st == 4'd8) && (op == BN));
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic instr(input logic [5:0] op, input string nm, input int n,
                       input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] s3, input logic [3:0] s4);
    logic [3:0] seq [5];
    seq = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < n; i++)
      step(1'b1, op, seq[i], $sformatf("%s_c%0d", nm, i));
  endtask

  initial begin : monitor
    vec_t e;
    string nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s actual=%h required=%h (state %0d vs %0d)", nm, act, e, act.state, e.state);
        end
      end
    end
  end

  initial begin : driver
    Reset = 1'b0;
    Op    = LW;
    for (int i = 0; i < 5; i++) step(1'b0, LW, 4'd0, $sformatf("reset_%0d", i));
    instr(LW, "lw", 5, 0, 1, 2, 3, 4);
    instr(RT, "rtype", 4, 0, 1, 6, 7, 0);
    instr(SW, "sw", 4, 0, 1, 2, 5, 0);
    instr(BQ, "beq", 3, 0, 1, 8, 0, 0);
    instr(JP, "j", 3, 0, 1, 9, 0, 0);
    instr(BAD, "illegal", 2, 0, 1, 0, 0, 0);
`ifdef MC_CTRL_BNE_EN
    instr(BN, "bne", 3, 0, 1, 8, 0, 0);
`else
    instr(BN, "bne_illegal", 2, 0, 1, 0, 0, 0);
`endif
    instr(AI, "addi", 4, 0, 1, 10, 11, 0);
    // Abort a store in MEMWR, then resume cleanly.
    instr(SW, "sw_abort", 3, 0, 1, 2, 0, 0);
    step(1'b0, SW, 4'd5, "abort_in_memwr");
    instr(RT, "after_abort", 4, 0, 1, 6, 7, 0);
    step(1'b1, LW, 4'd0, "final_fetch");
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
